// File: rtl/amo_rmw_sequencer_if.sv
// rtl/amo_rmw_sequencer_if.sv - request, memory and response bundle for the AMO sequencer
// Purpose: groups the three handshakes of the AMO read-modify-write sequencer.
//   req_*  : AMO issue (valid/ready, addr, operand, funct3, aq, rl)
//   mem_*  : single-port memory (req held until ack, we, addr, wdata, rdata)
//   rsp_*  : response (valid/ready, old value, error flag)
// Modports: slave = the sequencer, master = core issue + memory side.
interface amo_rmw_sequencer_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_data;
  logic [2:0]      req_funct3;
  logic            req_aq;
  logic            req_rl;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_err;

  modport slave (
    input  req_valid, req_addr, req_data, req_funct3, req_aq, req_rl,
    output req_ready,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output rsp_valid, rsp_data, rsp_err,
    input  rsp_ready
  );

  modport master (
    output req_valid, req_addr, req_data, req_funct3, req_aq, req_rl,
    input  req_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  rsp_valid, rsp_data, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/amo_rmw_sequencer.sv
// rtl/amo_rmw_sequencer.sv - one-at-a-time atomic read-modify-write sequencer
// Purpose: executes one AMO per accepted request as read then write on a
//   single-port memory, returning the pre-op value. rl requests wait for the
//   store buffer to drain first; aq holds off new requests until the response.
// Ports:
//   clk       rising-edge clock
//   rst_n     synchronous active-low reset
//   bus       amo_rmw_sequencer_if.slave (req_*, mem_*, rsp_*)
//   sb_empty  store buffer drained
//   busy      sequencer not idle
// Configuration: define AMO_MINMAX_EN to enable funct3 1xx (MIN/MAX/MINU/MAXU);
//   otherwise funct3 1xx returns an error without touching memory.
module amo_rmw_sequencer #(
  parameter int XLEN     = 32,
  parameter int ADDR_MAX = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  amo_rmw_sequencer_if.slave   bus,
  input  logic                 sb_empty,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, DRAIN, RD, WR, RESP} state_t;

  state_t          state, next_state;
  logic            started_q;   // keeps req_ready low in the cycle after a reset edge
  logic            aq_block_q;
  logic [XLEN-1:0] addr_q, data_q, old_q, new_q;
  logic [2:0]      funct3_q;
  logic            err_q;

  logic            ready_c, accept_c, bad_c, funct3_bad_c;
  logic            mem_req_c, mem_we_c, rsp_valid_c;
  logic [XLEN-1:0] mem_addr_c, mem_wdata_c, rsp_data_c, new_val_c;

`ifdef AMO_MINMAX_EN
  assign funct3_bad_c = 1'b0;
`else
  assign funct3_bad_c = bus.req_funct3[2];
`endif

  assign bad_c    = (bus.req_addr > XLEN'(ADDR_MAX)) || funct3_bad_c;
  assign ready_c  = (state == IDLE) && started_q && !aq_block_q;
  assign accept_c = bus.req_valid && ready_c;

  // New value is formed from the read data in the cycle it is acked.
  always_comb begin
    new_val_c = bus.mem_rdata;
    case (funct3_q)
      3'b000:  new_val_c = bus.mem_rdata + data_q;
      3'b001:  new_val_c = data_q;
      3'b010:  new_val_c = bus.mem_rdata & data_q;
      3'b011:  new_val_c = bus.mem_rdata | data_q;
`ifdef AMO_MINMAX_EN
      3'b100:  new_val_c = ($signed(bus.mem_rdata) < $signed(data_q)) ? bus.mem_rdata : data_q;
      3'b101:  new_val_c = ($signed(bus.mem_rdata) > $signed(data_q)) ? bus.mem_rdata : data_q;
      3'b110:  new_val_c = (bus.mem_rdata < data_q) ? bus.mem_rdata : data_q;
      3'b111:  new_val_c = (bus.mem_rdata > data_q) ? bus.mem_rdata : data_q;
`endif
      default: new_val_c = bus.mem_rdata;
    endcase
  end

  always_comb begin
    next_state  = state;
    mem_req_c   = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    rsp_valid_c = 1'b0;
    rsp_data_c  = '0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          if (bad_c)            next_state = RESP;
          else if (bus.req_rl)  next_state = DRAIN;
          else                  next_state = RD;
        end
      end
      DRAIN: begin
        if (sb_empty) next_state = RD;
      end
      RD: begin
        mem_req_c  = 1'b1;
        mem_addr_c = addr_q;
        if (bus.mem_ack) next_state = WR;
      end
      WR: begin
        mem_req_c   = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = addr_q;
        mem_wdata_c = new_q;
        if (bus.mem_ack) next_state = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        rsp_data_c  = old_q;
        if (bus.rsp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      started_q  <= 1'b0;
      aq_block_q <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      old_q      <= '0;
      new_q      <= '0;
      funct3_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state     <= next_state;
      started_q <= 1'b1;
      if (accept_c) begin
        addr_q     <= bus.req_addr;
        data_q     <= bus.req_data;
        funct3_q   <= bus.req_funct3;
        err_q      <= bad_c;
        old_q      <= '0;   // error responses report zero
        aq_block_q <= bus.req_aq;
      end
      if (state == RD && bus.mem_ack) begin
        old_q <= bus.mem_rdata;
        new_q <= new_val_c;
      end
      if (state == RESP && bus.rsp_ready) aq_block_q <= 1'b0;
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.mem_req   = mem_req_c;
  assign bus.mem_we    = mem_we_c;
  assign bus.mem_addr  = mem_addr_c;
  assign bus.mem_wdata = mem_wdata_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_data  = rsp_data_c;
  assign bus.rsp_err   = rsp_valid_c && err_q;
  assign busy          = (state != IDLE);

endmodule
